fanout_group_sequencer: RTL and testbench
=========================================

Name: fanout_group_sequencer

Overview:
- Sequenced driver for a buffered high-fanout output net: one logical input drives NUM_GROUPS groups of GROUP_WIDTH outputs, for example 4 groups of 5 outputs each.
- Outputs follow the input level, but groups are switched one at a time with a programmable gap. This limits simultaneous switching on the shared buffer tree.
- Sits between the input source and the per-group buffer/inverter stages that feed the output pins.

Parameters:
- NUM_GROUPS, 4, number of output groups; one group per buffer branch.
- GROUP_WIDTH, 5, outputs per group.
- GAP_W, 4, width of the stagger-gap counter and of the gap_cfg port.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_level  in  1  logical input level to distribute; synchronous to clk.
- gap_cfg  in  GAP_W  idle cycles between group updates; latched at sequence start.
- out_bus  out  NUM_GROUPS*GROUP_WIDTH  outputs; group g occupies bits [g*GROUP_WIDTH +: GROUP_WIDTH].
- busy  out  1  high while a sequence is in progress (state RUN).
- done  out  1  one-cycle pulse on the edge that updates the last group.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_bus=0, busy=0, done=0, state=IDLE.
  - Internal registers cleared: in_q=0, level=0, grp_idx=0, gap_cnt=0.
  - Asserting rst mid-sequence aborts the sequence immediately; partial group updates are discarded.
- in_q: registers in_level on every edge; the FSM uses only in_q.
- IDLE, on an edge with in_q != level:
  - target<=in_q; gap_lat<=gap_cfg.
  - Group 0 bits <= in_q (all bits of a group are always equal).
  - grp_idx<=1; gap_cnt<=gap_cfg; state<=RUN; busy<=1.
- IDLE, on an edge with in_q == level: no change.
- RUN, gap_cnt != 0: gap_cnt decrements by 1.
- RUN, gap_cnt == 0:
  - Group grp_idx bits <= target; gap_cnt<=gap_lat; grp_idx increments.
  - If grp_idx == NUM_GROUPS-1: state<=IDLE, level<=target, busy<=0, done<=1 for exactly one cycle, grp_idx<=0.
- Timing:
  - in_level changes before edge E0 (in_q updates at E0).
  - Group 0 updates at E1.
  - Group k updates at E1 + k*(gap_lat+1).
  - gap_cfg=0 updates groups on consecutive edges.
  - Total sequence length is 1 + (NUM_GROUPS-1)*(gap_lat+1) edges.
- NUM_GROUPS=1: group 0 update, done pulse and return to IDLE all occur at E1; busy never asserts.
- Changes of in_level during RUN do not alter target. On return to IDLE, in_q is re-compared with level on the next edge:
  - If it differs, a new sequence starts on that edge.
  - If in_level returned to the original level before completion, no new sequence starts.
- Changes of gap_cfg during RUN have no effect until the next sequence.
- Invariant: outside RUN, every out_bus bit equals level.
- Invariant: during RUN, groups [0, grp_idx) equal target and groups [grp_idx, NUM_GROUPS) equal the previous level.
- gap_cnt is unsigned and cannot underflow; a wrap from 0 is prohibited by the reload.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package fanout_seq_pkg:
  - State enum: IDLE, RUN.
  - Default constants: NUM_GROUPS=4, GROUP_WIDTH=5, GAP_W=4.
  - Function returning the bit slice of a group index.
- One natural sub-module: fanout_gap_timer (load/decrement counter with a zero flag), instanced once for gap_cnt.
- Group registers and the FSM stay in the top module.

Test Plan:
- Reset: hold rst=1 with in_level=1 -> out_bus=0, busy=0, done=0. Release rst -> first sequence starts two edges later.
- Rise, gap_cfg=2, defaults: in_level 0->1 before E0 ->
  - out_bus 0x0001F at E1, 0x003FF at E4, 0x07FFF at E7, 0xFFFFF at E10.
  - done high only in the E10 cycle; busy high from E1 to just before E10.
- Fall, gap_cfg=0, starting from all-ones -> out_bus 0xFFFE0, 0xFFC00, 0xF8000, 0x00000 on four consecutive edges; done at the fourth.
- Glitch: in_level pulses 0->1->0 for one cycle during RUN of a falling sequence -> sequence completes to 0; no new sequence; busy stays 0 afterwards.
- Pending change: in_level toggles to 0 at the midpoint of a rising sequence (gap_cfg=1) -> rising sequence completes with done; the falling sequence's group 0 update occurs on the edge after done. Also change gap_cfg mid-run -> the current spacing is unchanged.
- Async reset mid-RUN: assert rst between group 1 and group 2 updates -> out_bus=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fanout_seq_pkg.sv
// Shared types, default sizes and group slicing helper for the fanout group sequencer.
package fanout_seq_pkg;

    // Default geometry: 4 buffer branches of 5 outputs, 4-bit stagger gap
    localparam int NUM_GROUPS_DEF  = 4;
    localparam int GROUP_WIDTH_DEF = 5;
    localparam int GAP_W_DEF       = 4;

    // Sequencer state: IDLE holds all groups at the settled level, RUN walks the groups
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lowest out_bus bit index occupied by group idx
    function automatic int group_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fanout_gap_timer.sv
// Load/decrement counter used to space consecutive group updates.
// The count parks at zero rather than wrapping; the sequencer reloads it
// every time a group is switched.
module fanout_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] cnt;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fanout_group_sequencer.sv
// Sequenced driver for a buffered high-fanout net: one input level is
// distributed to NUM_GROUPS output groups, switched one group at a time with
// a programmable idle gap between groups to limit simultaneous switching.
module fanout_group_sequencer
    import fanout_seq_pkg::*;
#(
    parameter int NUM_GROUPS  = NUM_GROUPS_DEF,
    parameter int GROUP_WIDTH = GROUP_WIDTH_DEF,
    parameter int GAP_W       = GAP_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_level,
    input  logic [GAP_W-1:0]                  gap_cfg,
    output logic [NUM_GROUPS*GROUP_WIDTH-1:0] out_bus,
    output logic                              busy,
    output logic                              done
);

    localparam int IDX_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);
    localparam logic [IDX_W-1:0] FIRST_RUN_IDX = IDX_W'(1);

    state_t           state;
    logic             in_q;
    logic             level;
    logic             target;
    logic [GAP_W-1:0] gap_lat;
    logic [IDX_W-1:0] grp_idx;

    logic             tmr_load;
    logic             tmr_dec;
    logic [GAP_W-1:0] tmr_val;
    logic             gap_zero;

    // Gap counter control: load at sequence start and after each group
    // switch, otherwise count the idle gap down while running
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = gap_lat;
        case (state)
            IDLE: begin
                if (in_q != level) begin
                    tmr_load = 1'b1;
                    tmr_val  = gap_cfg;
                end
            end
            RUN: begin
                if (gap_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = gap_lat;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    fanout_gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .dec     (tmr_dec),
        .zero    (gap_zero)
    );

    // Sequencer FSM with registered group outputs and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            in_q    <= 1'b0;
            level   <= 1'b0;
            target  <= 1'b0;
            gap_lat <= '0;
            grp_idx <= '0;
            out_bus <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            in_q <= in_level;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_q != level) begin
                        target  <= in_q;
                        gap_lat <= gap_cfg;
                        out_bus[group_lsb(0, GROUP_WIDTH) +: GROUP_WIDTH] <= {GROUP_WIDTH{in_q}};
                        if (NUM_GROUPS == 1) begin
                            // Single group: the whole sequence is this one edge
                            level <= in_q;
                            done  <= 1'b1;
                        end else begin
                            grp_idx <= FIRST_RUN_IDX;
                            state   <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (gap_zero) begin
                        for (int g = 0; g < NUM_GROUPS; g++) begin
                            if (grp_idx == IDX_W'(g)) begin
                                out_bus[group_lsb(g, GROUP_WIDTH) +: GROUP_WIDTH] <= {GROUP_WIDTH{target}};
                            end
                        end
                        if (grp_idx == LAST_IDX) begin
                            state   <= IDLE;
                            level   <= target;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            grp_idx <= '0;
                        end else begin
                            grp_idx <= grp_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fanout_group_sequencer.sv
// Bench for fanout_group_sequencer: directed scenarios plus randomized
// stimulus against a schedule-based reference model.
module tb_fanout_group_sequencer;

    localparam int NG = 4;
    localparam int GW = 5;
    localparam int GAPW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_level = 1'b1;
    logic [GAPW-1:0]  gap_cfg = '0;
    logic [NG*GW-1:0] out_bus;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    fanout_group_sequencer #(
        .NUM_GROUPS (NG),
        .GROUP_WIDTH(GW),
        .GAP_W      (GAPW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_level(in_level),
        .gap_cfg (gap_cfg),
        .out_bus (out_bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: sequence is a schedule of group update edges
    // s + k*(gap+1), k = 0..NG-1, counted from the start edge s.
    int          cyc;
    logic        m_inq, m_level, m_tgt, m_active, m_done;
    int          m_s, m_gap;
    logic [NG-1:0] m_grp;
    logic [NG*GW-1:0] m_bus;
    logic        m_busy;

    task automatic model_reset();
        m_inq = 1'b0; m_level = 1'b0; m_tgt = 1'b0; m_active = 1'b0;
        m_done = 1'b0; m_grp = '0; m_s = 0; m_gap = 0;
        m_bus = '0; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        int d, k;
        m_done = 1'b0;
        if (m_active) begin
            d = cyc - m_s;
            if (d % (m_gap + 1) == 0) begin
                k = d / (m_gap + 1);
                m_grp[k] = m_tgt;
                if (k == NG - 1) begin
                    m_done   = 1'b1;
                    m_level  = m_tgt;
                    m_active = 1'b0;
                end
            end
        end else if (m_inq != m_level) begin
            m_s      = cyc;
            m_gap    = int'(gap_cfg);
            m_tgt    = m_inq;
            m_grp[0] = m_inq;
            if (NG == 1) begin
                m_done  = 1'b1;
                m_level = m_inq;
            end else begin
                m_active = 1'b1;
            end
        end
        m_inq = in_level;
        cyc++;
        for (int g = 0; g < NG; g++) m_bus[g*GW +: GW] = {GW{m_grp[g]}};
        m_busy = m_active;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle past it
    task automatic tick(input logic lvl, input logic [GAPW-1:0] gap);
        in_level = lvl;
        gap_cfg  = gap;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_bus !== '0) begin
            n_bad++; $display("FAIL reset_bus got=%h exp=%h", out_bus, {NG*GW{1'b0}});
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags got busy/done=%b exp=00", {busy, done});
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 4'd0);
            if (i == 0) begin
                n_cmp++;
                if (out_bus !== 20'h00000 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL reset_release_e0 got=%h busy=%b exp=00000 busy=0", out_bus, busy);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (out_bus !== 20'h0001F || busy !== 1'b1) begin
                    n_bad++; $display("FAIL reset_release_e1 got=%h busy=%b exp=0001f busy=1", out_bus, busy);
                end
            end
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL reset_seq i=%0d got=%h/%b%b exp=%h/%b%b", i, out_bus, busy, done, m_bus, m_busy, m_done);
            end
        end
    endtask

    task automatic test_fall();
        logic [NG*GW-1:0] exp_c [5];
        exp_c = '{20'hFFFFF, 20'hFFFE0, 20'hFFC00, 20'hF8000, 20'h00000};
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 4'd0);
            n_cmp++;
            if (out_bus !== exp_c[i] || done !== (i == 4)) begin
                n_bad++; $display("FAIL fall_const i=%0d got=%h done=%b exp=%h done=%b", i, out_bus, done, exp_c[i], (i == 4));
            end
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL fall_model i=%0d got=%h/%b%b exp=%h/%b%b", i, out_bus, busy, done, m_bus, m_busy, m_done);
            end
        end
    endtask

    task automatic test_rise();
        logic [NG*GW-1:0] exp_b;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 4'd2);
            exp_b = (i >= 10) ? 20'hFFFFF : (i >= 7) ? 20'h07FFF :
                    (i >= 4) ? 20'h003FF : (i >= 1) ? 20'h0001F : 20'h00000;
            n_cmp++;
            if (out_bus !== exp_b) begin
                n_bad++; $display("FAIL rise_bus i=%0d got=%h exp=%h", i, out_bus, exp_b);
            end
            n_cmp++;
            if (busy !== (i >= 1 && i < 10) || done !== (i == 10)) begin
                n_bad++; $display("FAIL rise_flags i=%0d got busy/done=%b%b exp=%b%b", i, busy, done, (i >= 1 && i < 10), (i == 10));
            end
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL rise_model i=%0d got=%h exp=%h", i, out_bus, m_bus);
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            tick((i == 3) ? 1'b1 : 1'b0, 4'd1);
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL glitch_model i=%0d got=%h/%b%b exp=%h/%b%b", i, out_bus, busy, done, m_bus, m_busy, m_done);
            end
            if (i >= 8) begin
                n_cmp++;
                if (out_bus !== 20'h00000 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL glitch_settled i=%0d got=%h busy=%b exp=00000 busy=0", i, out_bus, busy);
                end
            end
        end
    endtask

    task automatic test_pending();
        logic [GAPW-1:0] g;
        for (int i = 0; i < 13; i++) begin
            g = (i >= 7) ? 4'd0 : (i >= 4) ? 4'd7 : 4'd1;
            tick((i < 4) ? 1'b1 : 1'b0, g);
            if (i == 3 || i == 5 || i == 7 || i == 8 || i == 11) begin
                n_cmp++;
                case (i)
                    3: if (out_bus !== 20'h003FF) begin n_bad++; $display("FAIL pend_g1 got=%h exp=003ff", out_bus); end
                    5: if (out_bus !== 20'h07FFF) begin n_bad++; $display("FAIL pend_g2 got=%h exp=07fff", out_bus); end
                    7: if (out_bus !== 20'hFFFFF || done !== 1'b1) begin n_bad++; $display("FAIL pend_done got=%h done=%b exp=fffff done=1", out_bus, done); end
                    8: if (out_bus !== 20'hFFFE0 || busy !== 1'b1) begin n_bad++; $display("FAIL pend_restart got=%h busy=%b exp=fffe0 busy=1", out_bus, busy); end
                    default: if (out_bus !== 20'h00000 || done !== 1'b1) begin n_bad++; $display("FAIL pend_fall_done got=%h done=%b exp=00000 done=1", out_bus, done); end
                endcase
            end
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL pend_model i=%0d got=%h/%b%b exp=%h/%b%b", i, out_bus, busy, done, m_bus, m_busy, m_done);
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        lvl = m_level;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            tick(lvl, 4'($urandom_range(0, 3)));
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL random i=%0d got=%h/%b%b exp=%h/%b%b", i, out_bus, busy, done, m_bus, m_busy, m_done);
            end
        end
    endtask

    task automatic test_async_reset();
        in_level = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 4'd2);
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL arst_pre i=%0d got=%h exp=%h", i, out_bus, m_bus);
            end
        end
        n_cmp++;
        if (out_bus !== 20'h003FF) begin
            n_bad++; $display("FAIL arst_midrun got=%h exp=003ff", out_bus);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_bus !== 20'h00000 || {busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL arst_immediate got=%h busy/done=%b%b exp=00000 00", out_bus, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd2);
            n_cmp++;
            if (out_bus !== m_bus || {busy, done} !== {m_busy, m_done}) begin
                n_bad++; $display("FAIL arst_post i=%0d got=%h exp=%h", i, out_bus, m_bus);
            end
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_fall();
        test_rise();
        test_glitch();
        test_pending();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
